// File: rtl/dvfs_domain_sequencer_pkg.sv
// Shared definitions for the per-domain DVFS / power sequencer:
// state encoding, level type and default timing constants.
package dvfs_domain_sequencer_pkg;

   localparam int DEF_LEVEL_W    = 8;
   localparam int DEF_ISO_CYCLES = 2;
   localparam int DEF_PLL_BLANK  = 4;
   localparam int DEF_TIMEOUT    = 1024;

   typedef logic [DEF_LEVEL_W-1:0] level_t;

   typedef enum logic [3:0] {
      ST_IDLE_OFF   = 4'd0,
      ST_IDLE_ON    = 4'd1,
      ST_V_UP       = 4'd2,
      ST_F_SET      = 4'd3,
      ST_V_DOWN     = 4'd4,
      ST_CLK_GATE   = 4'd5,
      ST_ISO_ON     = 4'd6,
      ST_PWR_OFF    = 4'd7,
      ST_PWR_ON     = 4'd8,
      ST_PU_FSET    = 4'd9,
      ST_ISO_OFF    = 4'd10,
      ST_CLK_UNGATE = 4'd11,
      ST_ERROR      = 4'd12
   } dvfs_seq_state_t;

   function automatic logic is_idle(input dvfs_seq_state_t s);
      return (s == ST_IDLE_OFF) || (s == ST_IDLE_ON);
   endfunction

endpackage

// File: rtl/dvfs_domain_sequencer_seq_wait_timer.sv
// Loadable down-counter shared by the ISO steps, PLL blanking and the
// ack/lock timeout; expired is high while the count sits at zero.
module seq_wait_timer #(
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/dvfs_domain_sequencer.sv
// Per-domain sequencer: applies {power, voltage, frequency} requests to the
// regulator, PLL, isolation and power switch in a safe order.
module dvfs_domain_sequencer
   import dvfs_domain_sequencer_pkg::*;
#(
   parameter int LEVEL_W    = DEF_LEVEL_W,
   parameter int ISO_CYCLES = DEF_ISO_CYCLES,
   parameter int PLL_BLANK  = DEF_PLL_BLANK,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_power_en,
   input  logic [LEVEL_W-1:0] req_voltage,
   input  logic [LEVEL_W-1:0] req_frequency,
   output logic               vreg_set_valid,
   output logic [LEVEL_W-1:0] vreg_level,
   input  logic               vreg_ack,
   output logic               pll_set_valid,
   output logic [LEVEL_W-1:0] pll_level,
   input  logic               pll_lock,
   output logic               power_switch,
   output logic               isolation,
   output logic               clock_enable,
   output logic               cur_power_en,
   output logic [LEVEL_W-1:0] cur_voltage,
   output logic [LEVEL_W-1:0] cur_frequency,
   output logic               busy,
   output logic               done,
   output logic               error,
   output dvfs_seq_state_t    dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LD_TIMEOUT    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LD_POST_BLANK = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LD_BLANK      = CNT_W'(PLL_BLANK);
   localparam logic [CNT_W-1:0] LD_ISO        = CNT_W'(ISO_CYCLES - 1);

   dvfs_seq_state_t    state_q, state_d;
   logic               blank_q, blank_d;
   logic               tgt_pwr_q, tgt_pwr_d;
   logic [LEVEL_W-1:0] tgt_v_q, tgt_v_d;
   logic [LEVEL_W-1:0] tgt_f_q, tgt_f_d;
   logic               cur_pwr_q, cur_pwr_d;
   logic [LEVEL_W-1:0] cur_v_q, cur_v_d;
   logic [LEVEL_W-1:0] cur_f_q, cur_f_d;
   logic               ps_q, ps_d;
   logic               iso_q, iso_d;
   logic               ce_q, ce_d;
   logic               vset_q, vset_d;
   logic [LEVEL_W-1:0] vlvl_q, vlvl_d;
   logic               pset_q, pset_d;
   logic [LEVEL_W-1:0] plvl_q, plvl_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_expired;

   seq_wait_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   // Request handshake: a request is taken on any cycle where req_valid and
   // req_ready are both high; req_ready is high only in the two idle states.
   assign req_ready = is_idle(state_q);

   always_comb begin
      state_d   = state_q;
      blank_d   = blank_q;
      tgt_pwr_d = tgt_pwr_q;
      tgt_v_d   = tgt_v_q;
      tgt_f_d   = tgt_f_q;
      cur_pwr_d = cur_pwr_q;
      cur_v_d   = cur_v_q;
      cur_f_d   = cur_f_q;
      ps_d      = ps_q;
      iso_d     = iso_q;
      ce_d      = ce_q;
      vlvl_d    = vlvl_q;
      plvl_d    = plvl_q;
      vset_d    = 1'b0;
      pset_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      tmr_load  = 1'b0;
      tmr_val   = LD_TIMEOUT;

      case (state_q)
         ST_IDLE_OFF, ST_IDLE_ON: begin
            if (req_valid) begin
               tgt_pwr_d = req_power_en;
               tgt_v_d   = req_voltage;
               tgt_f_d   = req_frequency;
               if (state_q == ST_IDLE_OFF) begin
                  if (req_power_en) state_d = ST_PWR_ON;
                  else              done_d  = 1'b1;
               end else if (!req_power_en) begin
                  state_d = ST_CLK_GATE;
               end else if (req_voltage > cur_v_q) begin
                  state_d = ST_V_UP;
               end else if (req_frequency != cur_f_q) begin
                  state_d = ST_F_SET;
               end else if (req_voltage < cur_v_q) begin
                  state_d = ST_V_DOWN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         // An ack in the pulse cycle itself does not count as settled.
         ST_V_UP, ST_V_DOWN, ST_PWR_ON: begin
            if (!vset_q && vreg_ack) begin
               cur_v_d = tgt_v_q;
               if (state_q == ST_PWR_ON)     state_d = ST_PU_FSET;
               else if (state_q == ST_V_UP && tgt_f_q != cur_f_q) state_d = ST_F_SET;
               else                          state_d = ST_IDLE_ON;
            end else if (tmr_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_F_SET, ST_PU_FSET: begin
            if (blank_q) begin
               if (tmr_expired) begin
                  blank_d  = 1'b0;
                  tmr_load = 1'b1;
                  tmr_val  = LD_POST_BLANK;
               end
            end else if (pll_lock) begin
               cur_f_d = tgt_f_q;
               if (state_q == ST_PU_FSET)   state_d = ST_ISO_OFF;
               else if (tgt_v_q < cur_v_q)  state_d = ST_V_DOWN;
               else                         state_d = ST_IDLE_ON;
            end else if (tmr_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_CLK_GATE:   if (tmr_expired) state_d = ST_ISO_ON;
         ST_ISO_ON:     if (tmr_expired) state_d = ST_PWR_OFF;
         ST_PWR_OFF:    state_d = ST_IDLE_OFF;
         ST_ISO_OFF:    if (tmr_expired) state_d = ST_CLK_UNGATE;
         ST_CLK_UNGATE: state_d = ST_IDLE_ON;
         ST_ERROR:      state_d = ST_ERROR;
         default:       state_d = ST_ERROR;
      endcase

      // Entry actions: each state's pulse or control change lands on its first cycle.
      if (state_d != state_q) begin
         case (state_d)
            ST_V_UP, ST_V_DOWN, ST_PWR_ON: begin
               vset_d   = 1'b1;
               vlvl_d   = tgt_v_d;
               tmr_load = 1'b1;
               tmr_val  = LD_TIMEOUT;
               if (state_d == ST_PWR_ON) ps_d = 1'b1;
            end
            ST_F_SET, ST_PU_FSET: begin
               pset_d   = 1'b1;
               plvl_d   = tgt_f_d;
               blank_d  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = LD_BLANK;
            end
            ST_CLK_GATE: begin
               ce_d     = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = LD_ISO;
            end
            ST_ISO_ON: begin
               iso_d    = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = LD_ISO;
            end
            ST_ISO_OFF: begin
               iso_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = LD_ISO;
            end
            ST_PWR_OFF: ps_d = 1'b0;
            ST_CLK_UNGATE: begin
               ce_d      = 1'b1;
               cur_pwr_d = tgt_pwr_d;
            end
            ST_IDLE_OFF: begin
               cur_pwr_d = 1'b0;
               cur_v_d   = '0;
               cur_f_d   = '0;
               done_d    = 1'b1;
            end
            ST_IDLE_ON: done_d = 1'b1;
            ST_ERROR: begin
               ce_d  = 1'b0;
               iso_d = 1'b1;
               err_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE_OFF;
         blank_q   <= 1'b0;
         tgt_pwr_q <= 1'b0;
         tgt_v_q   <= '0;
         tgt_f_q   <= '0;
         cur_pwr_q <= 1'b0;
         cur_v_q   <= '0;
         cur_f_q   <= '0;
         ps_q      <= 1'b0;
         iso_q     <= 1'b1;
         ce_q      <= 1'b0;
         vset_q    <= 1'b0;
         vlvl_q    <= '0;
         pset_q    <= 1'b0;
         plvl_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         blank_q   <= blank_d;
         tgt_pwr_q <= tgt_pwr_d;
         tgt_v_q   <= tgt_v_d;
         tgt_f_q   <= tgt_f_d;
         cur_pwr_q <= cur_pwr_d;
         cur_v_q   <= cur_v_d;
         cur_f_q   <= cur_f_d;
         ps_q      <= ps_d;
         iso_q     <= iso_d;
         ce_q      <= ce_d;
         vset_q    <= vset_d;
         vlvl_q    <= vlvl_d;
         pset_q    <= pset_d;
         plvl_q    <= plvl_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign vreg_set_valid = vset_q;
   assign vreg_level     = vlvl_q;
   assign pll_set_valid  = pset_q;
   assign pll_level      = plvl_q;
   assign power_switch   = ps_q;
   assign isolation      = iso_q;
   assign clock_enable   = ce_q;
   assign cur_power_en   = cur_pwr_q;
   assign cur_voltage    = cur_v_q;
   assign cur_frequency  = cur_f_q;
   assign busy           = !is_idle(state_q);
   assign done           = done_q;
   assign error          = err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_dvfs_domain_sequencer.sv
// Directed plus randomized bench for dvfs_domain_sequencer, with a
// regulator/PLL responder and an event-level reference model.
module tb_dvfs_domain_sequencer;
   import dvfs_domain_sequencer_pkg::*;

   localparam int ISO = 2;
   localparam int PB  = 4;
   localparam int TO  = 1024;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   req_valid = 1'b0;
   logic   req_ready;
   logic   req_power_en = 1'b0;
   level_t req_voltage = '0;
   level_t req_frequency = '0;
   logic   vreg_set_valid;
   level_t vreg_level;
   logic   vreg_ack = 1'b0;
   logic   pll_set_valid;
   level_t pll_level;
   logic   pll_lock = 1'b0;
   logic   power_switch, isolation, clock_enable, cur_power_en;
   level_t cur_voltage, cur_frequency;
   logic   busy, done, error;
   dvfs_seq_state_t dbg_state;

   always #5 clk = ~clk;

   dvfs_domain_sequencer #(
      .LEVEL_W(8), .ISO_CYCLES(ISO), .PLL_BLANK(PB), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_power_en(req_power_en), .req_voltage(req_voltage), .req_frequency(req_frequency),
      .vreg_set_valid(vreg_set_valid), .vreg_level(vreg_level), .vreg_ack(vreg_ack),
      .pll_set_valid(pll_set_valid), .pll_level(pll_level), .pll_lock(pll_lock),
      .power_switch(power_switch), .isolation(isolation), .clock_enable(clock_enable),
      .cur_power_en(cur_power_en), .cur_voltage(cur_voltage), .cur_frequency(cur_frequency),
      .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Events: {8'h01, level} for a regulator set, {8'h02, level} for a PLL set.
   logic [15:0] exp_q[$];
   logic [15:0] obs_q[$];

   // Reference model of the applied domain state.
   logic   m_p;
   level_t m_v, m_f;
   level_t req_v_t, req_f_t, f_before;

   // Responder and trackers.
   bit v_pend, p_pend, no_ack, glitch, ack_last, lock_last, done_seen;
   bit ce_low_seen, iso_high_seen, ps_low_seen;
   int v_cnt, p_cnt, p_pulse_cyc, resp_cyc, first_evt_cyc, done_cyc;
   int ce_fall_cyc, ce_rise_cyc, iso_fall_cyc, iso_rise_cyc, ps_fall_cyc;
   logic prev_ce, prev_iso, prev_ps;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      int k;
      @(posedge clk);
      #1;
      cyc++;
      k = cyc - p_pulse_cyc;
      if (ack_last)  check("cur_v_after_ack", cur_voltage, req_v_t);
      if (lock_last) check("cur_f_after_lock", cur_frequency, req_f_t);
      if (glitch && p_pend && k >= 2 && k <= 3) check("f_hold_in_blank", cur_frequency, f_before);
      ack_last  = 1'b0;
      lock_last = 1'b0;
      if (done && !done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
      if (prev_ce && !clock_enable)  ce_fall_cyc  = cyc;
      if (!prev_ce && clock_enable)  ce_rise_cyc  = cyc;
      if (prev_iso && !isolation)    iso_fall_cyc = cyc;
      if (!prev_iso && isolation)    iso_rise_cyc = cyc;
      if (prev_ps && !power_switch)  ps_fall_cyc  = cyc;
      if (!clock_enable) ce_low_seen   = 1'b1;
      if (isolation)     iso_high_seen = 1'b1;
      if (!power_switch) ps_low_seen   = 1'b1;
      prev_ce = clock_enable; prev_iso = isolation; prev_ps = power_switch;

      vreg_ack = 1'b0;
      if (vreg_set_valid) begin
         obs_q.push_back({8'h01, vreg_level});
         if (first_evt_cyc < 0) first_evt_cyc = cyc;
         v_pend = 1'b1;
         v_cnt  = int'($urandom_range(1, 5));
      end else if (v_pend) begin
         v_cnt--;
         if (v_cnt == 0 && !no_ack) begin
            vreg_ack = 1'b1; v_pend = 1'b0; ack_last = 1'b1; resp_cyc = cyc;
         end
      end else if ($urandom_range(0, 7) == 0) begin
         vreg_ack = 1'b1;
      end

      if (pll_set_valid) begin
         obs_q.push_back({8'h02, pll_level});
         if (first_evt_cyc < 0) first_evt_cyc = cyc;
         p_pend = 1'b1;
         p_pulse_cyc = cyc;
         p_cnt = PB + int'($urandom_range(1, 4));
         pll_lock = 1'b0;
      end else if (p_pend) begin
         p_cnt--;
         if (p_cnt == 0) begin
            pll_lock = 1'b1; p_pend = 1'b0; lock_last = 1'b1; resp_cyc = cyc;
         end else begin
            pll_lock = glitch && (k <= 2);
         end
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, req_ready, 1'b1);
      check({tag, "_pswitch"}, power_switch, 1'b0);
      check({tag, "_iso"}, isolation, 1'b1);
      check({tag, "_clken"}, clock_enable, 1'b0);
      check({tag, "_cur"}, {cur_power_en, cur_voltage, cur_frequency}, 17'd0);
      check({tag, "_busy_done_err"}, {busy, done, error}, 3'b000);
      check({tag, "_pulses"}, {vreg_set_valid, pll_set_valid}, 2'b00);
   endtask

   task automatic do_reset();
      ack_last = 1'b0; lock_last = 1'b0; glitch = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      v_pend = 1'b0; p_pend = 1'b0; no_ack = 1'b0;
      vreg_ack = 1'b0; pll_lock = 1'b0;
      ack_last = 1'b0; lock_last = 1'b0;
      m_p = 1'b0; m_v = '0; m_f = '0;
      prev_ce = clock_enable; prev_iso = isolation; prev_ps = power_switch;
   endtask

   task automatic do_req(input logic p, input level_t v, input level_t f);
      int n, acc;
      bit pd, pu, dv;
      pd = m_p && !p;
      pu = !m_p && p;
      dv = m_p && p;
      check("ready_before_req", req_ready, 1'b1);
      exp_q.delete();
      obs_q.delete();
      if (pu) begin
         exp_q.push_back({8'h01, v});
         exp_q.push_back({8'h02, f});
      end else if (dv) begin
         if (v > m_v) begin
            exp_q.push_back({8'h01, v});
            if (f != m_f) exp_q.push_back({8'h02, f});
         end else begin
            if (f != m_f) exp_q.push_back({8'h02, f});
            if (v < m_v) exp_q.push_back({8'h01, v});
         end
      end
      done_seen = 1'b0; first_evt_cyc = -1; resp_cyc = -1;
      ce_fall_cyc = -1; ce_rise_cyc = -1; iso_fall_cyc = -1; iso_rise_cyc = -1; ps_fall_cyc = -1;
      ce_low_seen = 1'b0; iso_high_seen = 1'b0; ps_low_seen = 1'b0;
      req_v_t = v; req_f_t = f; f_before = m_f;
      req_valid = 1'b1; req_power_en = p; req_voltage = v; req_frequency = f;
      acc = cyc;
      tick();
      req_valid = 1'b0;
      req_power_en = 1'($urandom); req_voltage = 8'($urandom); req_frequency = 8'($urandom);
      n = 0;
      while (!done_seen && n < 3000) begin tick(); n++; end
      check("done_seen", done_seen, 1'b1);
      check("ready_in_done_cycle", req_ready, 1'b1);
      check("event_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check("event", obs_q[i], exp_q[i]);
      if (pd) begin
         check("pd_clk_gate_at", ce_fall_cyc - acc, 1);
         check("pd_iso_on_at", iso_rise_cyc - acc, 1 + ISO);
         check("pd_pwr_off_at", ps_fall_cyc - acc, 1 + 2 * ISO);
         check("pd_done_at", done_cyc - acc, 2 * ISO + 2);
      end else if (pu) begin
         check("pu_first_pulse_at", first_evt_cyc - acc, 1);
         check("pu_iso_off_after_lock", iso_fall_cyc - resp_cyc, 1);
         check("pu_clk_on_after_iso", ce_rise_cyc - iso_fall_cyc, ISO);
         check("pu_done_after_clk", done_cyc - ce_rise_cyc, 1);
      end else if (exp_q.size() != 0) begin
         check("dvfs_first_pulse_at", first_evt_cyc - acc, 1);
         check("dvfs_done_after_resp", done_cyc - resp_cyc, 1);
         check("dvfs_domain_undisturbed", {ce_low_seen, iso_high_seen, ps_low_seen}, 3'b000);
      end else begin
         check("noop_done_at", done_cyc - acc, 1);
      end
      if (p) begin m_p = 1'b1; m_v = v; m_f = f; end
      else   begin m_p = 1'b0; m_v = '0; m_f = '0; end
      check("cur_state", {cur_power_en, cur_voltage, cur_frequency}, {m_p, m_v, m_f});
      check("domain_controls", {power_switch, isolation, clock_enable}, {m_p, !m_p, m_p});
      check("idle_flags", {busy, error}, 2'b00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      level_t lv_tab [4];
      int n, err_cyc;
      logic rp;
      level_t rv, rf;
      lv_tab[0] = 8'h10; lv_tab[1] = 8'h40; lv_tab[2] = 8'h80; lv_tab[3] = 8'hC0;
      p_pulse_cyc = -100;
      prev_ce = 1'b0; prev_iso = 1'b1; prev_ps = 1'b0;
      tick();
      do_reset();
      check_reset("por");

      do_req(1'b1, 8'hC0, 8'hC0);            // power-up from reset
      glitch = 1'b1;
      do_req(1'b1, 8'hFF, 8'hFF);            // V then F, lock glitch in blanking
      glitch = 1'b0;
      do_req(1'b1, 8'h40, 8'h40);            // F then V
      do_req(1'b1, 8'h40, 8'h40);            // identical request
      do_req(1'b1, 8'h80, 8'h40);            // issued in the done cycle
      do_req(1'b0, 8'h33, 8'h77);            // power-down
      do_req(1'b0, 8'h12, 8'h34);            // off while off

      for (int i = 0; i < 30; i++) begin
         rp = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 1) != 0) ? lv_tab[$urandom_range(0, 3)] : 8'($urandom);
         rf = ($urandom_range(0, 1) != 0) ? lv_tab[$urandom_range(0, 3)] : 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin rp = m_p; rv = m_v; rf = m_f; end
         do_req(rp, rv, rf);
      end

      // Reset in the middle of a power-up.
      do_reset();
      req_valid = 1'b1; req_power_en = 1'b1; req_voltage = 8'h90; req_frequency = 8'h60;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      do_reset();
      check_reset("mid_seq");

      // Regulator never acknowledges.
      no_ack = 1'b1; done_seen = 1'b0; first_evt_cyc = -1;
      req_valid = 1'b1; req_power_en = 1'b1; req_voltage = 8'h55; req_frequency = 8'h22;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!error && n < 1200) begin tick(); n++; end
      err_cyc = cyc;
      check("to_error_set", error, 1'b1);
      check("to_error_latency", err_cyc - first_evt_cyc, TO + 1);
      check("to_controls", {clock_enable, isolation, power_switch}, 3'b011);
      check("to_ready_busy", {req_ready, busy}, 2'b01);
      check("to_state", dbg_state, ST_ERROR);
      repeat (5) tick();
      check("to_sticky", {error, req_ready}, 2'b10);
      check("to_no_done", done_seen, 1'b0);
      do_reset();
      check_reset("after_err");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dvfs_domain_sequencer.md
# dvfs_domain_sequencer

Per-domain responder for power-manager commands: accepts a target {power enable, voltage level, frequency level} request and executes it on the domain's voltage regulator, PLL, isolation cells and power switch in a safe order. Voltage is raised before frequency and lowered after it. Power-down order is clock gate, isolate, switch off; power-up runs in reverse. One instance sits between the power manager and each power domain's physical controls.

## Interface
- LEVEL_W, 8, width of voltage/frequency level codes
- ISO_CYCLES, 2, cycles held in each clock-gate / isolate / de-isolate step
- PLL_BLANK, 4, cycles pll_lock is ignored after pll_set_valid
- TIMEOUT, 1024, max cycles waiting for vreg_ack or pll_lock
- Reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  sequencer idle, request accepted when req_valid&&req_ready
- req_power_en  in  1  target domain power state
- req_voltage  in  LEVEL_W  target voltage code
- req_frequency  in  LEVEL_W  target frequency code
- vreg_set_valid  out  1  one-cycle regulator set pulse
- vreg_level  out  LEVEL_W  regulator target, valid with vreg_set_valid
- vreg_ack  in  1  regulator settled pulse
- pll_set_valid  out  1  one-cycle PLL set pulse
- pll_level  out  LEVEL_W  PLL target, valid with pll_set_valid
- pll_lock  in  1  PLL lock level
- power_switch  out  1  domain power switch on
- isolation  out  1  domain outputs isolated
- clock_enable  out  1  domain clock running
- cur_power_en, cur_voltage, cur_frequency  out  1/LEVEL_W/LEVEL_W  applied state
- busy  out  1  not in an idle state
- done  out  1  one-cycle pulse on request completion
- error  out  1  sticky timeout flag

## Operation
- States:
  - Idle: IDLE_OFF, IDLE_ON.
  - Voltage/frequency change: V_UP, F_SET, V_DOWN.
  - Power-down: CLK_GATE, ISO_ON, PWR_OFF.
  - Power-up: PWR_ON, PU_FSET, ISO_OFF, CLK_UNGATE.
  - Fault: ERROR.
- Reset values:
  - State IDLE_OFF.
  - power_switch=0, isolation=1, clock_enable=0.
  - cur_*=0, busy=0, done=0, error=0.
  - All set pulses 0.
  - Latched target = 0.
- req_ready=1 only in IDLE_OFF/IDLE_ON. Target fields are latched on acceptance.
- IDLE_ON, power_en=1:
  - V_t>V_cur: V_UP → F_SET (if F_t≠F_cur) → IDLE_ON.
  - V_t≤V_cur: F_SET (if F_t≠F_cur) → V_DOWN (if V_t<V_cur) → IDLE_ON.
  - Request identical to current state: no regulator/PLL traffic; straight to IDLE_ON with done.
- IDLE_ON, power_en=0: CLK_GATE (clock_enable=0) → ISO_ON (isolation=1) → PWR_OFF (power_switch=0, 1 cycle) → IDLE_OFF. CLK_GATE and ISO_ON last ISO_CYCLES each.
- IDLE_OFF, power_en=1: PWR_ON → PU_FSET → ISO_OFF → CLK_UNGATE → IDLE_ON.
  - PWR_ON: power_switch=1, vreg set to V_t, wait vreg_ack.
  - PU_FSET: PLL set to F_t, wait lock.
  - ISO_OFF: isolation=0, ISO_CYCLES.
  - CLK_UNGATE: clock_enable=1, 1 cycle.
- IDLE_OFF, power_en=0: no action; done pulse.
- Voltage wait (V_UP/V_DOWN/PWR_ON):
  - vreg_set_valid is pulsed in the first state cycle, then the state waits for vreg_ack.
  - cur_voltage updates on the ack cycle.
- Frequency wait (F_SET/PU_FSET):
  - pll_set_valid is pulsed in the first state cycle.
  - pll_lock is ignored for PLL_BLANK cycles, then the state waits for pll_lock=1.
  - cur_frequency updates on lock.
- vreg_ack and pll_lock outside wait windows are ignored.
- Entering IDLE_OFF: cur_voltage=cur_frequency=0, cur_power_en=0. CLK_UNGATE sets cur_power_en=1.
- Timeout: a wait counter reaches TIMEOUT without ack/lock → ERROR.
  - ERROR forces clock_enable=0 and isolation=1; power_switch is held.
  - error=1, req_ready=0.
  - No done pulse.
  - Only rst_n exits ERROR.
- Reset asserted mid-sequence returns all outputs to reset values on the next clk edge.

## Timing
- Acceptance at cycle N → first sequence state at N+1, where its set pulse or control change occurs.
- done asserts in the first idle cycle after completion; req_ready is also 1 that cycle, so back-to-back requests are legal.
- Minimum power-down, acceptance to done: 2·ISO_CYCLES+2 cycles.
- vreg_ack counted from the cycle after vreg_set_valid. Ack in that cycle gives 1-cycle wait, so state advances at +2.
- TIMEOUT count excludes the PLL blanking window.
- Comparisons are unsigned LEVEL_W.

## Structure
- Shared power package provides:
  - the dvfs_seq_state_t enum;
  - the level_t typedef (LEVEL_W bits);
  - default ISO_CYCLES/PLL_BLANK/TIMEOUT constants.
- Sub-module seq_wait_timer: loadable down-counter with expire flag; used for ISO steps, PLL blanking and timeout.

## Test plan
- Power-up from reset: req {1,0xC0,0xC0}.
  - Required response: vreg_set_valid with 0xC0, then pll_set_valid with 0xC0, isolation 1→0, clock_enable 1, done.
  - Final outputs: cur={1,0xC0,0xC0}.
- Scale up, V then F: req {1,0xFF,0xFF} from 0xC0.
  - Required response: vreg pulse precedes pll pulse.
  - Required response: pll_lock toggled high during blanking is ignored.
- Scale down, F then V: req {1,0x40,0x40}.
  - Required response: pll pulse first, then vreg pulse with 0x40.
  - Required response: clock_enable stays 1 throughout.
- Power-down with ISO_CYCLES=2: req {0,x,x}.
  - Required response: clock_enable→0, isolation→1 two cycles later, power_switch→0 two cycles after that.
  - Required response: done at acceptance+6, cur_*=0.
- Timeout: withhold vreg_ack for 1024 cycles.
  - Required response: error=1, clock_enable=0, isolation=1, req_ready=0, no done.
  - Required response: rst_n low for one edge restores reset values.
- Identical request and back-to-back: repeat current request, then issue a new request in the done cycle.
  - Required response: no set pulses for the identical request.
  - Required response: the second request is accepted in the done cycle.
